// File: rtl/y_mem_resp.sv
// y_mem_resp: 32-bit word store that answers each request after LATENCY wait cycles.
// Define YMEM_MISALIGN_CHECK_EN to flag (and suppress) accesses with addr[1:0] != 0.
module y_mem_resp #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic        err
);

  localparam int         DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] LAT   = 4'(LATENCY);

  // Handshake: req/we/addr/wdata are sampled only on an edge where the block is
  // idle (busy=0); busy stays high from that accept edge until the response edge,
  // and ack pulses for the single cycle after it, with rdata and err valid then.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_next;
  logic [3:0] cnt, cnt_next;

  logic                  we_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [31:0]           wdata_q;
  logic [31:0]           mem [DEPTH];

  logic accept;
  logic respond;
  logic bad;
  logic do_write;
  logic unused_addr;

  assign accept      = (state == IDLE) && req;
  assign respond     = (state == RESP);
  assign busy        = (state != IDLE);
  assign unused_addr = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};

`ifdef YMEM_MISALIGN_CHECK_EN
  logic mis_q;

  always_ff @(posedge clk) begin
    if (accept) begin
      mis_q <= (addr[1:0] != 2'b00);
    end
  end

  assign bad = mis_q;
`else
  assign bad = 1'b0;
`endif

  // A reset landing on the response edge must cancel the store as well.
  assign do_write = respond && !rst && we_q && !bad;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          cnt_next   = LAT;
          state_next = (LAT == 4'd0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          cnt_next   = 4'd0;
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Request fields are frozen at accept so later input wiggles cannot leak in.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= we;
      idx_q   <= addr[DEPTH_LOG2+1:2];
      wdata_q <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack   <= 1'b0;
      rdata <= 32'd0;
    end else begin
      ack <= respond;
      if (respond && !we_q && !bad) begin
        rdata <= mem[idx_q];
      end
    end
  end

`ifdef YMEM_MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
      err <= respond && bad;
    end
  end
`else
  assign err = 1'b0;
`endif

  // Storage is deliberately left out of reset so contents survive it.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[idx_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_y_mem_resp.sv
// Bench for y_mem_resp: a LATENCY=2 and a LATENCY=0 instance checked against
// a word-array model of the storage and of the last read data.
module tb_y_mem_resp;

  localparam bit MIS_EN =
`ifdef YMEM_MISALIGN_CHECK_EN
    1'b1;
`else
    1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        ack   [2];
  logic        busy  [2];
  logic        err   [2];

  int checks   = 0;
  int failures = 0;

  logic [31:0] model_mem   [2][1024];
  logic [31:0] model_rdata [2];

  always #5 clk = ~clk;

  y_mem_resp #(.DEPTH_LOG2(10), .LATENCY(2)) u_dut_lat2 (
    .clk(clk), .rst(rst), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .wdata(wdata[0]), .rdata(rdata[0]), .ack(ack[0]), .busy(busy[0]), .err(err[0])
  );

  y_mem_resp #(.DEPTH_LOG2(10), .LATENCY(0)) u_dut_lat0 (
    .clk(clk), .rst(rst), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .wdata(wdata[1]), .rdata(rdata[1]), .ack(ack[1]), .busy(busy[1]), .err(err[1])
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic bit misaligned(input logic [31:0] a);
    return MIS_EN && ((a % 32'd4) != 32'd0);
  endfunction

  task automatic txn(input int d, input logic w, input logic [31:0] a,
                     input logic [31:0] wd, input bit scramble, input string name);
    int          n;
    int          word;
    bit          mis;
    logic [31:0] exp_rdata;
    mis  = misaligned(a);
    word = int'((a / 32'd4) % 32'd1024);
    exp_rdata = (!w && !mis) ? model_mem[d][word] : model_rdata[d];

    @(negedge clk);
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
    @(negedge clk);
    req[d] = 1'b0;
    if (scramble) begin
      we[d] = ~w; addr[d] = $urandom(); wdata[d] = $urandom();
    end
    n = 0;
    while (ack[d] !== 1'b1 && n < 40) begin
      checks++;
      if (busy[d] !== 1'b1) begin
        failures++;
        $display("FAIL %s busy d=%0d cyc=%0d got=%b exp=1", name, d, n, busy[d]);
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != lat_of(d) + 1) begin
      failures++;
      $display("FAIL %s latency d=%0d got=%0d exp=%0d", name, d, n, lat_of(d) + 1);
    end
    checks++;
    if (err[d] !== mis) begin
      failures++;
      $display("FAIL %s err d=%0d got=%b exp=%b", name, d, err[d], mis);
    end
    checks++;
    if (busy[d] !== 1'b0) begin
      failures++;
      $display("FAIL %s busy_at_ack d=%0d got=%b exp=0", name, d, busy[d]);
    end
    checks++;
    if (rdata[d] !== exp_rdata) begin
      failures++;
      $display("FAIL %s rdata d=%0d addr=%h got=%h exp=%h", name, d, a, rdata[d], exp_rdata);
    end
    if (!mis && w) model_mem[d][word] = wd;
    model_rdata[d] = exp_rdata;
    @(negedge clk);
    checks++;
    if (ack[d] !== 1'b0) begin
      failures++;
      $display("FAIL %s ack_pulse d=%0d got=%b exp=0", name, d, ack[d]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ack[d] !== 1'b0 || busy[d] !== 1'b0 || err[d] !== 1'b0 || rdata[d] !== 32'd0) begin
        failures++;
        $display("FAIL reset d=%0d got ack=%b busy=%b err=%b rdata=%h exp 0/0/0/0",
                 d, ack[d], busy[d], err[d], rdata[d]);
      end
      model_rdata[d] = 32'd0;
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, "write_10");
  endtask

  task automatic test_back_to_back();
    int          n;
    logic [31:0] exp_rd;
    exp_rd = model_mem[0][4];
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10;
    @(negedge clk);
    n = 0;
    while (ack[0] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 3 || rdata[0] !== exp_rd || busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first lat=%0d rdata=%h busy=%b exp 3/%h/0", n, rdata[0], busy[0], exp_rd);
    end
    @(negedge clk);
    checks++;
    if (busy[0] !== 1'b1) begin
      failures++;
      $display("FAIL b2b_reaccept busy got=%b exp=1", busy[0]);
    end
    req[0] = 1'b0;
    n = 0;
    while (ack[0] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 3 || rdata[0] !== exp_rd) begin
      failures++;
      $display("FAIL b2b_second lat=%0d rdata=%h exp 3/%h", n, rdata[0], exp_rd);
    end
    model_rdata[0] = exp_rd;
    @(negedge clk);
  endtask

  task automatic test_latency0();
    txn(1, 1'b1, 32'h4, 32'h1234, 1'b0, "lat0_write");
    txn(1, 1'b0, 32'h4, 32'h0, 1'b0, "lat0_read");
  endtask

  task automatic test_wrap();
    txn(0, 1'b1, 32'h1000, 32'hA5A5A5A5, 1'b1, "wrap_write");
    txn(0, 1'b0, 32'h0, 32'h0, 1'b1, "wrap_read");
  endtask

  task automatic test_reset_abort();
    bit saw_ack;
    txn(0, 1'b1, 32'h20, 32'h0, 1'b0, "abort_prep");
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'hFFFFFFFF;
    @(negedge clk);
    req[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy[0] !== 1'b0 || ack[0] !== 1'b0 || rdata[0] !== 32'd0) begin
      failures++;
      $display("FAIL abort_state busy=%b ack=%b rdata=%h exp 0/0/0", busy[0], ack[0], rdata[0]);
    end
    model_rdata[0] = 32'd0;
    model_rdata[1] = 32'd0;
    saw_ack = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ack[0] === 1'b1) saw_ack = 1'b1;
    end
    checks++;
    if (saw_ack) begin
      failures++;
      $display("FAIL abort_no_ack got=1 exp=0");
    end
    txn(0, 1'b0, 32'h20, 32'h0, 1'b0, "abort_read");
    @(negedge clk);
    rst = 1'b1; req[0] = 1'b1; req[1] = 1'b1; we[0] = 1'b0; we[1] = 1'b0;
    addr[0] = 32'h20; addr[1] = 32'h20;
    @(negedge clk);
    rst = 1'b0; req[0] = 1'b0; req[1] = 1'b0;
    checks++;
    if (busy[0] !== 1'b0 || busy[1] !== 1'b0) begin
      failures++;
      $display("FAIL rst_priority busy0=%b busy1=%b exp 0/0", busy[0], busy[1]);
    end
    model_rdata[0] = 32'd0;
    model_rdata[1] = 32'd0;
  endtask

  task automatic test_misalign();
    txn(0, 1'b1, 32'h22, 32'h12345678, 1'b0, "mis_write");
    txn(0, 1'b0, 32'h20, 32'h0, 1'b0, "mis_check");
    txn(0, 1'b0, 32'h23, 32'h0, 1'b0, "mis_read");
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) txn(d, 1'b1, 32'(i * 4), $urandom(), 1'b0, "rnd_fill");
      for (int k = 0; k < 30; k++) begin
        a = $urandom();
        a[11:6] = 6'd0;
        if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
        txn(d, 1'($urandom_range(0, 1)), a, $urandom(), 1'($urandom_range(0, 1)), "rnd");
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; addr[d] = 32'd0; wdata[d] = 32'd0;
    end
    test_reset();
    test_basic();
    test_back_to_back();
    test_latency0();
    test_wrap();
    test_reset_abort();
    test_misalign();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
